// File: rtl/reg_file_sb_pkg.sv
// Shared CPU register-file definitions: default geometry, address-width helper
// and the index of the hard-wired zero register.
package reg_file_sb_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREG  = 8;
    localparam int REG_ZERO  = 0;

    // Address width for a register file of n entries (n is a power of two, >= 2).
    function automatic int addr_bits(input int n);
        return $clog2(n);
    endfunction

    // One register-file write (writeback) request.
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } wr_req_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode, cleared by writeback.
// A set and a clear to the same register in one cycle leaves it pending.
module rf_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int NREG     = DEF_NREG,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       we,
    input  logic [addr_bits(NREG)-1:0] waddr,
    input  logic                       sb_set,
    input  logic [addr_bits(NREG)-1:0] sb_addr,
    input  logic [addr_bits(NREG)-1:0] raddr_a,
    input  logic [addr_bits(NREG)-1:0] raddr_b,
    output logic                       busy_a,
    output logic                       busy_b
);

    localparam int AW = addr_bits(NREG);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_next;

    always_comb begin
        pend_next = pend;
        if (we) begin
            pend_next[waddr] = 1'b0;
        end
        if (sb_set) begin
            pend_next[sb_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_next[REG_ZERO] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // A register being written this cycle is reported free when its data is
    // forwarded, unless decode is re-marking it as pending in the same cycle.
    function automatic logic busy_lookup(input logic [AW-1:0] ra);
        logic fwd;
        fwd = (BYPASS != 0) && we && (waddr == ra) && !(sb_set && (sb_addr == ra));
        return pend[ra] && !fwd;
    endfunction

    always_comb begin
        busy_a = busy_lookup(raddr_a);
        busy_b = busy_lookup(raddr_b);
    end

endmodule

// File: rtl/reg_file_sb.sv
// NREG x WIDTH CPU register file with two combinational read ports, one write port,
// optional hard-wired zero register, write-to-read bypass and pending-write scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NREG     = DEF_NREG,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       we,
    input  logic [addr_bits(NREG)-1:0] waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [addr_bits(NREG)-1:0] raddr_a,
    input  logic [addr_bits(NREG)-1:0] raddr_b,
    output logic [WIDTH-1:0]           rdata_a,
    output logic [WIDTH-1:0]           rdata_b,
    output logic                       busy_a,
    output logic                       busy_b,
    input  logic                       sb_set,
    input  logic [addr_bits(NREG)-1:0] sb_addr
);

    localparam int AW = addr_bits(NREG);

    logic [WIDTH-1:0] regs [NREG];
    logic             wr_en;

    always_comb begin
        wr_en = we;
        if ((ZERO_REG != 0) && (waddr == AW'(REG_ZERO))) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Zero register takes precedence over forwarding.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
        logic [WIDTH-1:0] d;
        d = regs[ra];
        if ((BYPASS != 0) && we && (waddr == ra)) begin
            d = wdata;
        end
        if ((ZERO_REG != 0) && (ra == AW'(REG_ZERO))) begin
            d = '0;
        end
        return d;
    endfunction

    always_comb begin
        rdata_a = read_port(raddr_a);
        rdata_b = read_port(raddr_b);
    end

    rf_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .CLK     (CLK),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .busy_a  (busy_a),
        .busy_b  (busy_b)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and model-checked bench for reg_file_sb, with a bypassing and a
// non-bypassing instance sharing the same stimulus.
module tb_reg_file_sb;

    logic        CLK = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic        sb_set;
    logic [2:0]  sb_addr;

    logic [15:0] rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
    logic        busy_a, busy_b, nb_busy_a, nb_busy_b;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [15:0] mregs [8];
    logic        mpend [8];

    always #5 CLK = ~CLK;

    reg_file_sb #(.WIDTH(16), .NREG(8), .ZERO_REG(1), .BYPASS(1)) dut (
        .CLK(CLK), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .busy_a(busy_a), .busy_b(busy_b), .sb_set(sb_set), .sb_addr(sb_addr)
    );

    reg_file_sb #(.WIDTH(16), .NREG(8), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .CLK(CLK), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(nb_rdata_a), .rdata_b(nb_rdata_b),
        .busy_a(nb_busy_a), .busy_b(nb_busy_b), .sb_set(sb_set), .sb_addr(sb_addr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [2:0] wa,
                                 input logic [15:0] wd, input logic s, input logic [2:0] sa,
                                 input logic [2:0] ra, input logic [2:0] rb);
        reset = r; we = w; waddr = wa; wdata = wd;
        sb_set = s; sb_addr = sa; raddr_a = ra; raddr_b = rb;
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] exp_rd(input logic [2:0] ra, input bit byp);
        if (ra == 3'd0) return 16'h0;
        if (byp && we && waddr == ra) return wdata;
        return mregs[ra];
    endfunction

    function automatic logic exp_busy(input logic [2:0] ra, input bit byp);
        if (byp && we && waddr == ra && !(sb_set && sb_addr == ra)) return 1'b0;
        return mpend[ra];
    endfunction

    initial begin
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        @(negedge CLK);

        // 1: reset beats a concurrent write
        applyStimulus(1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd3);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd3);
        checkOutput("reset_reg3", 32'(rdata_a), 32'h0);
        checkOutput("reset_busy_a", 32'(busy_a), 32'h0);
        checkOutput("reset_busy_b", 32'(busy_b), 32'h0);

        // 2: same-cycle bypass vs. no bypass
        applyStimulus(1'b0, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd5, 3'd1);
        checkOutput("bypass_rd", 32'(rdata_a), 32'h1234);
        checkOutput("nobypass_old", 32'(nb_rdata_a), 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd1);
        checkOutput("nobypass_next", 32'(nb_rdata_a), 32'h1234);
        checkOutput("bypass_stored", 32'(rdata_a), 32'h1234);

        // 3: zero register ignores writes and scoreboard marks
        applyStimulus(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd0);
        checkOutput("zero_rd_same", 32'(rdata_a), 32'h0);
        checkOutput("zero_busy_same", 32'(busy_a), 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        checkOutput("zero_rd_after", 32'(rdata_a), 32'h0);
        checkOutput("zero_busy_after", 32'(busy_a), 32'h0);

        // 4: set then clear a pending bit
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd2, 3'd2);
        checkOutput("sb2_before", 32'(busy_b), 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2, 3'd2);
        checkOutput("sb2_busy_b", 32'(busy_b), 32'h1);
        checkOutput("sb2_busy_a", 32'(busy_a), 32'h1);
        applyStimulus(1'b0, 1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 3'd2, 3'd2);
        checkOutput("sb2_fwd_busy", 32'(busy_b), 32'h0);
        checkOutput("sb2_nofwd_busy", 32'(nb_busy_b), 32'h1);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2, 3'd2);
        checkOutput("sb2_cleared", 32'(busy_b), 32'h0);
        checkOutput("sb2_nb_cleared", 32'(nb_busy_b), 32'h0);
        checkOutput("sb2_data", 32'(rdata_b), 32'h2222);

        // 5: set/clear collisions
        applyStimulus(1'b0, 1'b1, 3'd4, 16'h4444, 1'b1, 3'd4, 3'd4, 3'd4);
        checkOutput("sb4_same_cycle", 32'(busy_a), 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd4, 3'd4);
        checkOutput("sb4_set_wins", 32'(busy_a), 32'h1);
        checkOutput("sb4_data", 32'(rdata_a), 32'h4444);
        applyStimulus(1'b0, 1'b1, 3'd4, 16'h4545, 1'b1, 3'd6, 3'd6, 3'd4);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd6, 3'd4);
        checkOutput("sb6_set", 32'(busy_a), 32'h1);
        checkOutput("sb4_clear", 32'(busy_b), 32'h0);
        checkOutput("sb4_data2", 32'(rdata_b), 32'h4545);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 3'd6, 3'd6);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd6, 3'd6);
        checkOutput("sb6_reset_twice", 32'(busy_a), 32'h1);
        applyStimulus(1'b0, 1'b1, 3'd6, 16'h6666, 1'b1, 3'd6, 3'd6, 3'd6);
        checkOutput("sb6_reissue_busy", 32'(busy_a), 32'h1);
        checkOutput("sb6_reissue_fwd", 32'(rdata_a), 32'h6666);
        step();

        // 6: both ports on one register
        applyStimulus(1'b0, 1'b1, 3'd7, 16'hA5A5, 1'b0, 3'd0, 3'd1, 3'd1);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd7, 3'd7);
        checkOutput("dual_a", 32'(rdata_a), 32'hA5A5);
        checkOutput("dual_b", 32'(rdata_b), 32'hA5A5);

        // mid-operation reset drops pending marks (reg 6 still pending here)
        applyStimulus(1'b1, 1'b1, 3'd6, 16'h1111, 1'b1, 3'd3, 3'd6, 3'd3);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd6, 3'd3);
        checkOutput("midreset_busy6", 32'(busy_a), 32'h0);
        checkOutput("midreset_busy3", 32'(busy_b), 32'h0);
        checkOutput("midreset_reg6", 32'(rdata_a), 32'h0);

        for (int i = 0; i < 8; i++) begin
            mregs[i] = 16'h0;
            mpend[i] = 1'b0;
        end

        $display("[TB] random phase");
        for (int c = 0; c < 1000; c++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            checkOutput("rnd_rd_a", 32'(rdata_a), 32'(exp_rd(raddr_a, 1'b1)));
            checkOutput("rnd_rd_b", 32'(rdata_b), 32'(exp_rd(raddr_b, 1'b1)));
            checkOutput("rnd_busy_a", 32'(busy_a), 32'(exp_busy(raddr_a, 1'b1)));
            checkOutput("rnd_busy_b", 32'(busy_b), 32'(exp_busy(raddr_b, 1'b1)));
            checkOutput("rnd_nb_rd_a", 32'(nb_rdata_a), 32'(exp_rd(raddr_a, 1'b0)));
            checkOutput("rnd_nb_rd_b", 32'(nb_rdata_b), 32'(exp_rd(raddr_b, 1'b0)));
            checkOutput("rnd_nb_busy_a", 32'(nb_busy_a), 32'(exp_busy(raddr_a, 1'b0)));
            checkOutput("rnd_nb_busy_b", 32'(nb_busy_b), 32'(exp_busy(raddr_b, 1'b0)));
            if (we && waddr != 3'd0) mregs[waddr] = wdata;
            if (we) mpend[waddr] = 1'b0;
            if (sb_set && sb_addr != 3'd0) mpend[sb_addr] = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
